// File: rtl/fm_tap_capture.sv
// Per-source FM tap: trigger-armed, prescaled burst capture of a ULT pipeline stream
// into registered fm_rt data/valid records, plus saturating monitoring counters.
module fm_tap_capture #(
    parameter int DATA_WIDTH     = 64,
    parameter int PRESCALE_WIDTH = 16,
    parameter int BURST_WIDTH    = 12,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk_hs,
    input  logic                      rst_hs,
    input  logic                      enable,
    input  logic                      arm,
    input  logic                      trigger,
    input  logic                      freeze,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [BURST_WIDTH-1:0]    burst_len,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_valid,
    output logic [DATA_WIDTH-1:0]     fm_data,
    output logic                      fm_valid,
    output logic [1:0]                state_o,
    output logic [BURST_WIDTH-1:0]    words_captured,
    output logic [CNT_WIDTH-1:0]      dropped_cnt,
    output logic [CNT_WIDTH-1:0]      burst_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] prescale_sh_q, prescale_sh_d;
    logic [PRESCALE_WIDTH-1:0] prescale_cnt_q, prescale_cnt_d;
    logic [BURST_WIDTH-1:0]    burst_sh_q, burst_sh_d;
    logic [BURST_WIDTH-1:0]    words_q, words_d;
    logic [BURST_WIDTH:0]      words_inc;
    logic [DATA_WIDTH-1:0]     fm_data_q, fm_data_d;
    logic                      fm_valid_q, fm_valid_d;
    logic [CNT_WIDTH-1:0]      dropped_q, dropped_d;
    logic [CNT_WIDTH-1:0]      burst_cnt_q, burst_cnt_d;

    logic cap_active, word_in, emit, last_word, cont_exit, arm_take;

    // State register.
    always_ff @(posedge clk_hs) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_hs) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; enable low overrides every other transition.
    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:    if (arm) state_d = S_ARMED;
                S_ARMED:   if (trigger) state_d = last_word ? S_DONE : S_CAPTURE;
                S_CAPTURE: begin
                    if (arm && burst_sh_q == '0) state_d = S_ARMED;
                    else if (last_word)          state_d = S_DONE;
                end
                S_DONE:    if (arm) state_d = S_ARMED;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Output decode: the trigger cycle itself is already a capture cycle.
    always_comb begin
        cap_active = 1'b0;
        unique case (state_q)
            S_ARMED:   cap_active = enable && trigger;
            S_CAPTURE: cap_active = 1'b1;
            default:   cap_active = 1'b0;
        endcase
    end

    assign state_o   = state_q;
    assign word_in   = cap_active && in_valid;
    assign emit      = word_in && !freeze && (prescale_cnt_q == '0);
    assign words_inc = {1'b0, words_q} + (BURST_WIDTH + 1)'(1);
    assign last_word = emit && (burst_sh_q != '0) && (words_inc == {1'b0, burst_sh_q});
    assign cont_exit = (state_q == S_CAPTURE) && (burst_sh_q == '0) && (!enable || arm);
    assign arm_take  = (state_d == S_ARMED) && (state_q != S_ARMED);

    always_comb begin
        prescale_sh_d  = prescale_sh_q;
        burst_sh_d     = burst_sh_q;
        prescale_cnt_d = prescale_cnt_q;
        words_d        = words_q;
        fm_data_d      = fm_data_q;
        fm_valid_d     = emit;
        dropped_d      = dropped_q;
        burst_cnt_d    = burst_cnt_q;

        if (word_in && freeze && dropped_q != '1)
            dropped_d = dropped_q + CNT_WIDTH'(1);
        if (word_in && !freeze)
            prescale_cnt_d = (prescale_cnt_q == '0) ? prescale_sh_q
                                                    : prescale_cnt_q - PRESCALE_WIDTH'(1);
        if (emit) begin
            fm_data_d = in_data;
            if (words_q != '1) words_d = words_inc[BURST_WIDTH-1:0];
        end
        if ((last_word || cont_exit) && burst_cnt_q != '1)
            burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
        // Arming snapshots the configuration and restarts the burst bookkeeping.
        if (arm_take) begin
            prescale_sh_d  = prescale;
            burst_sh_d     = burst_len;
            prescale_cnt_d = '0;
            words_d        = '0;
        end
    end

    always_ff @(posedge clk_hs) begin
        if (rst_hs) begin
            prescale_sh_q  <= '0;
            burst_sh_q     <= '0;
            prescale_cnt_q <= '0;
            words_q        <= '0;
            fm_data_q      <= '0;
            fm_valid_q     <= 1'b0;
            dropped_q      <= '0;
            burst_cnt_q    <= '0;
        end else begin
            prescale_sh_q  <= prescale_sh_d;
            burst_sh_q     <= burst_sh_d;
            prescale_cnt_q <= prescale_cnt_d;
            words_q        <= words_d;
            fm_data_q      <= fm_data_d;
            fm_valid_q     <= fm_valid_d;
            dropped_q      <= dropped_d;
            burst_cnt_q    <= burst_cnt_d;
        end
    end

    assign fm_data        = fm_data_q;
    assign fm_valid       = fm_valid_q;
    assign words_captured = words_q;
    assign dropped_cnt    = dropped_q;
    assign burst_cnt      = burst_cnt_q;

endmodule

// File: tb/tb_fm_tap_capture.sv
// Self-checking bench for fm_tap_capture: directed vector table, corner-case
// sequences and randomized traffic against a rule-level reference model.
module tb_fm_tap_capture;

    localparam longint unsigned MAXC = 64'h0000_0000_FFFF_FFFF;

    logic        clk_hs = 1'b0;
    logic        rst_hs, enable, arm, trigger, freeze, in_valid;
    logic [15:0] prescale;
    logic [11:0] burst_len;
    logic [63:0] in_data, fm_data;
    logic        fm_valid;
    logic [1:0]  state_o;
    logic [11:0] words_captured;
    logic [31:0] dropped_cnt, burst_cnt;

    fm_tap_capture dut (
        .clk_hs(clk_hs), .rst_hs(rst_hs), .enable(enable), .arm(arm),
        .trigger(trigger), .freeze(freeze), .prescale(prescale),
        .burst_len(burst_len), .in_data(in_data), .in_valid(in_valid),
        .fm_data(fm_data), .fm_valid(fm_valid), .state_o(state_o),
        .words_captured(words_captured), .dropped_cnt(dropped_cnt),
        .burst_cnt(burst_cnt)
    );

    always #5 clk_hs = ~clk_hs;

    typedef struct {
        bit          rst, en, arm, trg, frz, vld;
        logic [63:0] data;
        int          ps, bl;
    } in_t;

    typedef struct {
        in_t         i;
        bit          e_valid;
        logic [63:0] e_data;
        int          e_state, e_words, e_drop, e_burst;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference model state (plain integers, rule-level).
    int              m_state, m_ps, m_bl, m_since, m_words;
    longint unsigned m_drop, m_burst;
    bit              m_valid;
    logic [63:0]     m_data;

    int          cyc = 0;
    int          pulse_cnt = 0;
    logic [63:0] emitted_q[$];
    int          pulse_idx[$];
    int          cfg_ps, cfg_bl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic do_arm(input in_t v);
        m_state = 1;
        m_ps    = v.ps;
        m_bl    = v.bl;
        m_since = v.ps;  // first eligible word is always kept
        m_words = 0;
    endtask

    task automatic model_step(input in_t v);
        bit capturing, emitted, burst_end, exit_cont;
        int old;
        if (v.rst) begin
            m_state = 0; m_ps = 0; m_bl = 0; m_since = 0; m_words = 0;
            m_drop = 0; m_burst = 0; m_valid = 0; m_data = '0;
            return;
        end
        old       = m_state;
        capturing = (old == 2) || (old == 1 && v.en && v.trg);
        emitted   = 0;
        if (capturing && v.vld) begin
            if (v.frz) begin
                if (m_drop < MAXC) m_drop++;
            end else if (m_since >= m_ps) begin
                emitted = 1;
                m_since = 0;
            end else begin
                m_since++;
            end
        end
        burst_end = emitted && m_bl != 0 && (m_words + 1 == m_bl);
        exit_cont = (old == 2) && (m_bl == 0) && (!v.en || v.arm);
        m_valid = emitted;
        if (emitted) begin
            m_data = v.data;
            if (m_words < 4095) m_words++;
        end
        if ((burst_end || exit_cont) && m_burst < MAXC) m_burst++;
        if (!v.en) begin
            m_state = 0;
        end else begin
            case (old)
                0: if (v.arm) do_arm(v);
                1: if (v.trg) m_state = burst_end ? 3 : 2;
                2: begin
                    if (m_bl == 0 && v.arm) do_arm(v);
                    else if (burst_end)     m_state = 3;
                end
                default: if (v.arm) do_arm(v);
            endcase
        end
    endtask

    task automatic apply_cycle(input in_t v);
        rst_hs    = v.rst;
        enable    = v.en;
        arm       = v.arm;
        trigger   = v.trg;
        freeze    = v.frz;
        in_valid  = v.vld;
        in_data   = v.data;
        prescale  = 16'(v.ps);
        burst_len = 12'(v.bl);
        model_step(v);
        @(posedge clk_hs);
        #1;
        check("fm_valid", {63'd0, fm_valid}, {63'd0, m_valid});
        check("fm_data", fm_data, m_data);
        check("state_o", {62'd0, state_o}, 64'(m_state));
        check("words_captured", {52'd0, words_captured}, 64'(m_words));
        check("dropped_cnt", {32'd0, dropped_cnt}, m_drop);
        check("burst_cnt", {32'd0, burst_cnt}, m_burst);
        if (fm_valid === 1'b1) begin
            pulse_cnt++;
            emitted_q.push_back(fm_data);
            pulse_idx.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic step(input bit en, input bit a, input bit t, input bit f,
                        input bit vl, input logic [63:0] d);
        in_t v;
        v.rst = 0; v.en = en; v.arm = a; v.trg = t; v.frz = f; v.vld = vl;
        v.data = d; v.ps = cfg_ps; v.bl = cfg_bl;
        apply_cycle(v);
    endtask

    task automatic clear_obs();
        pulse_cnt = 0;
        emitted_q.delete();
        pulse_idx.delete();
    endtask

    vec_t tbl[10];

    function automatic vec_t mkv(input bit rst, input bit en, input bit a, input bit t,
                                 input bit f, input bit vl, input logic [63:0] d,
                                 input int ps, input int bl, input bit ev,
                                 input logic [63:0] ed, input int es, input int ew,
                                 input int edr, input int eb);
        vec_t r;
        r.i.rst = rst; r.i.en = en; r.i.arm = a; r.i.trg = t; r.i.frz = f;
        r.i.vld = vl; r.i.data = d; r.i.ps = ps; r.i.bl = bl;
        r.e_valid = ev; r.e_data = ed; r.e_state = es; r.e_words = ew;
        r.e_drop = edr; r.e_burst = eb;
        return r;
    endfunction

    int freeze_pulses;

    initial begin
        // Reset with inputs toggling, then a prescale=0, burst_len=4 burst over 0x10..
        tbl[0] = mkv(1, 1, 1, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 3, 7, 0, 64'h0, 0, 0, 0, 0);
        tbl[1] = mkv(1, 1, 0, 1, 0, 1, 64'h1234, 1, 2, 0, 64'h0, 0, 0, 0, 0);
        tbl[2] = mkv(0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0, 64'h0, 0, 0, 0, 0);
        tbl[3] = mkv(0, 1, 1, 0, 0, 1, 64'hAA, 0, 4, 0, 64'h0, 1, 0, 0, 0);
        tbl[4] = mkv(0, 1, 0, 1, 0, 1, 64'h10, 0, 4, 1, 64'h10, 2, 1, 0, 0);
        tbl[5] = mkv(0, 1, 0, 0, 0, 1, 64'h11, 5, 1, 1, 64'h11, 2, 2, 0, 0);
        tbl[6] = mkv(0, 1, 0, 0, 0, 1, 64'h12, 5, 1, 1, 64'h12, 2, 3, 0, 0);
        tbl[7] = mkv(0, 1, 0, 0, 0, 1, 64'h13, 0, 4, 1, 64'h13, 3, 4, 0, 1);
        tbl[8] = mkv(0, 1, 0, 0, 0, 1, 64'h14, 0, 4, 0, 64'h13, 3, 4, 0, 1);
        tbl[9] = mkv(0, 1, 0, 0, 0, 1, 64'h15, 0, 4, 0, 64'h13, 3, 4, 0, 1);

        for (int k = 0; k < 10; k++) begin
            apply_cycle(tbl[k].i);
            check("tbl_valid", {63'd0, fm_valid}, {63'd0, tbl[k].e_valid});
            check("tbl_data", fm_data, tbl[k].e_data);
            check("tbl_state", {62'd0, state_o}, 64'(tbl[k].e_state));
            check("tbl_words", {52'd0, words_captured}, 64'(tbl[k].e_words));
            check("tbl_dropped", {32'd0, dropped_cnt}, 64'(tbl[k].e_drop));
            check("tbl_burst", {32'd0, burst_cnt}, 64'(tbl[k].e_burst));
        end

        // Prescale 2, burst 3: words 0, 3, 6 with two idle cycles between pulses.
        cfg_ps = 2; cfg_bl = 3;
        clear_obs();
        step(1, 1, 0, 0, 0, 64'h0);
        for (int i = 0; i < 12; i++) step(1, 0, i == 0, 0, 1, 64'(i));
        check("ps_pulses", 64'(pulse_cnt), 64'd3);
        if (emitted_q.size() == 3) begin
            check("ps_word0", emitted_q[0], 64'd0);
            check("ps_word1", emitted_q[1], 64'd3);
            check("ps_word2", emitted_q[2], 64'd6);
            check("ps_gap01", 64'(pulse_idx[1] - pulse_idx[0]), 64'd3);
            check("ps_gap12", 64'(pulse_idx[2] - pulse_idx[1]), 64'd3);
        end
        check("ps_state", {62'd0, state_o}, 64'd3);
        check("ps_burst", {32'd0, burst_cnt}, 64'd2);

        // Burst of 8 with three frozen words in the middle.
        cfg_ps = 0; cfg_bl = 8;
        clear_obs();
        freeze_pulses = 0;
        step(1, 1, 0, 0, 0, 64'h0);
        for (int i = 0; i < 3; i++) step(1, 0, i == 0, 0, 1, 64'(32'h200 + i));
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 1, 64'(32'h300 + i));
            if (fm_valid === 1'b1) freeze_pulses++;
        end
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 1, 64'(32'h400 + i));
        check("frz_pulses", 64'(pulse_cnt), 64'd8);
        check("frz_no_valid", 64'(freeze_pulses), 64'd0);
        check("frz_dropped", {32'd0, dropped_cnt}, 64'd3);
        check("frz_words", {52'd0, words_captured}, 64'd8);
        check("frz_state", {62'd0, state_o}, 64'd3);

        // Continuous mode: 20 words, the last coinciding with enable going low.
        cfg_ps = 0; cfg_bl = 0;
        clear_obs();
        step(1, 1, 0, 0, 0, 64'h0);
        for (int i = 0; i < 20; i++) step(i != 19, 0, i == 0, 0, 1, 64'(100 + i));
        check("cont_pulses", 64'(pulse_cnt), 64'd20);
        check("cont_last_word", fm_data, 64'd119);
        check("cont_state", {62'd0, state_o}, 64'd0);
        check("cont_burst", {32'd0, burst_cnt}, 64'd4);

        // Reset after 2 of 5 words, then a fresh 2-word burst.
        cfg_ps = 0; cfg_bl = 5;
        step(1, 1, 0, 0, 0, 64'h0);
        step(1, 0, 1, 0, 1, 64'h50);
        step(1, 0, 0, 0, 1, 64'h51);
        begin
            in_t v;
            v.rst = 1; v.en = 1; v.arm = 0; v.trg = 0; v.frz = 0; v.vld = 1;
            v.data = 64'h52; v.ps = 0; v.bl = 5;
            apply_cycle(v);
        end
        check("rst_valid", {63'd0, fm_valid}, 64'd0);
        check("rst_state", {62'd0, state_o}, 64'd0);
        cfg_bl = 2;
        clear_obs();
        step(1, 1, 0, 0, 0, 64'h0);
        for (int i = 0; i < 4; i++) step(1, 0, i == 0, 0, 1, 64'(32'h60 + i));
        check("rearm_pulses", 64'(pulse_cnt), 64'd2);
        check("rearm_words", {52'd0, words_captured}, 64'd2);
        check("rearm_burst", {32'd0, burst_cnt}, 64'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            in_t v;
            v.rst  = ($urandom_range(0, 199) == 0);
            v.en   = ($urandom_range(0, 99) < 95);
            v.arm  = ($urandom_range(0, 99) < 5);
            v.trg  = ($urandom_range(0, 99) < 20);
            v.frz  = ($urandom_range(0, 99) < 15);
            v.vld  = ($urandom_range(0, 99) < 70);
            v.data = {$urandom, $urandom};
            v.ps   = $urandom_range(0, 3);
            v.bl   = $urandom_range(0, 6);
            apply_cycle(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fm_tap_capture.md
Name: fm_tap_capture

Overview:
- Per-source front end for the fast-monitoring (FM) spy buffers. It sits directly upstream of the FM block and produces one entry of its ult_fm_data array.
- Taps a ULT pipeline stream, applies trigger-armed burst capture with prescaling, and emits registered data/valid records in the fm_rt format.
- Also produces monitoring counters for the FM status registers.
- Runs entirely in the clk_hs domain.

Parameters:
- DATA_WIDTH, 64, width of the tapped data word and of the fm_rt data field.
- PRESCALE_WIDTH, 16, width of the prescale setting; keeps 1 of every (prescale+1) valid words.
- BURST_WIDTH, 12, width of the burst-length setting and of the captured-word counter.
- CNT_WIDTH, 32, width of the monitoring counters.

Ports:
- clk_hs  in  1  high-speed fabric clock.
- rst_hs  in  1  synchronous, active-high reset.
- enable  in  1  block enable. Low forces IDLE.
- arm  in  1  single-cycle pulse: IDLE/DONE -> ARMED, latches the configuration.
- trigger  in  1  start-capture strobe, honoured only in ARMED.
- freeze  in  1  freeze from the spy-buffer control. While high, no fm_valid is emitted.
- prescale  in  PRESCALE_WIDTH  keep 1 of (prescale+1) valid words. 0 keeps every word.
- burst_len  in  BURST_WIDTH  number of words to emit per burst. 0 means continuous capture until disarmed.
- in_data  in  DATA_WIDTH  tapped pipeline data.
- in_valid  in  1  tapped pipeline valid.
- fm_data  out  DATA_WIDTH  data field of the fm_rt record to the FM block.
- fm_valid  out  1  valid field of the fm_rt record.
- state_o  out  2  current state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- words_captured  out  BURST_WIDTH  words emitted in the current/last burst.
- dropped_cnt  out  CNT_WIDTH  valid words discarded by freeze during CAPTURE. Saturating.
- burst_cnt  out  CNT_WIDTH  completed bursts. Saturating.

Behaviour:
- Reset: rst_hs is sampled on the clk_hs edge. All outputs, the state register, and the prescale counter go to 0. The latched configuration goes to 0.
- Latching: on arm, prescale and burst_len are captured into shadow registers. Changing the inputs mid-burst has no effect.
- IDLE:
  - arm && enable -> ARMED.
  - The prescale counter and words_captured clear on entry to ARMED.
- ARMED:
  - trigger -> CAPTURE.
  - If in_valid is high in the trigger cycle, that word is eligible as the first capture.
  - enable low -> IDLE.
- CAPTURE: each in_valid cycle is evaluated in this order:
  - If freeze is high: the word is dropped, dropped_cnt increments, and the prescale counter is not advanced.
  - Otherwise, if prescale_cnt == 0: the word is emitted and prescale_cnt reloads to the shadow prescale.
  - Otherwise: the word is skipped and prescale_cnt decrements.
- Output timing: an emitted word appears on fm_data/fm_valid exactly one cycle after the input cycle (latency 1).
  - fm_valid is a single-cycle pulse per word.
  - fm_data holds its last value when fm_valid is low.
- Word counting and burst end:
  - words_captured increments per emitted word and saturates at all-ones.
  - When burst_len != 0 and the emitted word is the burst_len-th, the state moves to DONE in the same edge that registers the word, and burst_cnt increments.
- Continuous mode (burst_len == 0): the block stays in CAPTURE until enable goes low or arm is pulsed.
  - Exit to IDLE on enable low.
  - Re-arm -> ARMED.
  - burst_cnt increments on either exit.
- DONE:
  - Holds words_captured.
  - arm -> ARMED.
  - enable low -> IDLE.
- Simultaneous events:
  - arm and trigger in the same IDLE cycle -> ARMED only; the trigger is ignored.
  - enable low has priority over all other transitions.
  - A last-word emission in the same cycle as enable going low still outputs the word, still counts it, and still increments burst_cnt; the state then goes to IDLE.
- Reset mid-burst: returns to IDLE next edge. Any pending output is not issued (fm_valid = 0 after reset).
- Counters: dropped_cnt and burst_cnt saturate at 2^CNT_WIDTH-1 and are cleared only by reset.
- in_valid low: nothing is counted or decremented in any state.

Test Plan:
- Reset with all inputs toggling -> all outputs 0, state_o = 0 for every cycle reset is held and the first cycle after.
- arm, trigger, prescale = 0, burst_len = 4, in_valid continuous with data 0x10..0x17 -> fm_valid on 4 consecutive cycles, data 0x10..0x13, one cycle after each input. state_o = 3, words_captured = 4, burst_cnt = 1.
- prescale = 2, burst_len = 3, continuous valid with data 0..11 -> emitted words 0, 3, 6. Gaps of 2 cycles between fm_valid pulses.
- burst_len = 8, freeze high for 3 valid cycles mid-burst -> dropped_cnt = 3, no fm_valid during the freeze, burst still completes with 8 words after freeze drops.
- burst_len = 0, 20 valid words, then enable low -> 20 fm_valid pulses, state_o = 0, burst_cnt = 1. A word on the last cycle is still emitted.
- Reset asserted after 2 of 5 words, then re-arm with burst_len = 2 -> no fm_valid in the cycle after reset. The new burst emits exactly 2 words and words_captured = 2.
